// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with prefetch FIFO, in-order PC queue and redirect flush.
// Optional feature macro: IF_ALIGN_CHECK_EN. When it is defined, a misaligned redirect target halts fetch and raises fault_o.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   imem_req_o/imem_addr_o       word fetch request and byte address to instruction memory
//   imem_gnt_i                   memory accepts the current request
//   imem_rvalid_i/imem_rdata_i   in-order response from instruction memory
//   redirect_i/redirect_pc_i     taken branch/jump: flush and refetch from the new PC
//   valid_o/ready_i              handshake toward decode
//   instr_o/pc_o                 FIFO head instruction and its PC
//   fault_o                      misaligned redirect detected (always 0 without the macro)
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = FIFO_DEPTH[CW:0];
`ifdef IF_ALIGN_CHECK_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif
    state_t state, state_nxt;
    logic [31:0] fetch_pc, tgt;
    logic [CW-1:0] outstanding, drop_cnt, fifo_count;
    logic [AW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;
    logic [31:0] fifo_pc [FIFO_DEPTH];
    logic [31:0] fifo_instr [FIFO_DEPTH];
    logic [31:0] pc_q [FIFO_DEPTH];
    logic run, redir, grant, push, pop;

    assign run = state == RUN;
    assign redir = run && redirect_i;
    assign grant = imem_req_o && imem_gnt_i;
    // responses landing in a redirect cycle, or still owed to a flushed stream, are never stored
    assign push = run && !redirect_i && imem_rvalid_i && drop_cnt == '0;
    assign pop = valid_o && ready_i;
    assign tgt = redirect_pc_i & 32'hFFFF_FFFC;
    // buffered plus in-flight words may never exceed the buffer, so a push always has room
    assign imem_req_o = run && !redirect_i && ({1'b0, fifo_count} + {1'b0, outstanding} < DEPTH);
    assign imem_addr_o = fetch_pc;
    assign valid_o = fifo_count != '0;
    assign instr_o = valid_o ? fifo_instr[rd_ptr] : '0;
    assign pc_o = valid_o ? fifo_pc[rd_ptr] : '0;
`ifdef IF_ALIGN_CHECK_EN
    assign fault_o = state == HALT;
`else
    assign fault_o = 1'b0;
`endif

    always_comb begin
        state_nxt = state == BOOT ? RUN : state;
`ifdef IF_ALIGN_CHECK_EN
        if (redir && redirect_pc_i[1:0] != 2'b00) state_nxt = HALT;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pq_rd       <= '0;
            pq_wr       <= '0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= redir ? tgt : grant ? fetch_pc + 32'd4 : fetch_pc;
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
            // the PC queue tracks every granted request, including ones later dropped
            if (grant) pq_wr <= pq_wr + AW'(1);
            if (imem_rvalid_i) pq_rd <= pq_rd + AW'(1);
            // on redirect every word still in flight belongs to the old stream
            drop_cnt <= redir ? outstanding + CW'(grant) - CW'(imem_rvalid_i) :
                        (imem_rvalid_i && drop_cnt != '0) ? drop_cnt - CW'(1) : drop_cnt;
            if (redir) begin
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                fifo_count <= fifo_count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) pc_q[pq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= pc_q[pq_rd];
            fifo_instr[wr_ptr] <= imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch with an in-order memory model and an expected-PC scoreboard.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o, valid_o, fault_o;
    logic        imem_gnt_i = 1'b1, imem_rvalid_i = 1'b0, redirect_i = 1'b0, ready_i = 1'b1;
    logic [31:0] imem_addr_o, instr_o, pc_o;
    logic [31:0] imem_rdata_i = '0, redirect_pc_i = '0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .pc_o(pc_o), .fault_o(fault_o)
    );

    typedef struct {logic [31:0] addr; int due;} req_t;
    typedef struct {logic ready; logic req; logic [31:0] addr; logic valid; logic [31:0] pc;} vec_t;
    req_t        mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;
    int          cyc = 0, lat = 1, grants = 0, g0;
    int          n_chk = 0, n_fail = 0;
    vec_t        tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        redirect_i = 1'b0;
        ready_i = 1'b1;
        imem_gnt_i = 1'b1;
        lat = l;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected outputs missing, next pc %h", name, exp_q.size(), exp_q[0]);
            exp_q.delete();
        end
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_i = 1'b1;
        redirect_pc_i = a;
    endtask

    // memory: samples requests mid-cycle, answers in order after lat cycles with data ~addr
    initial forever begin
        @(negedge clk);
        if (rst) mq.delete();
        else if (imem_req_o && imem_gnt_i) begin
            mq.push_back('{imem_addr_o, cyc + lat});
            grants++;
        end
        step();
        cyc++;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i = ~mq[0].addr;
            void'(mq.pop_front());
        end else imem_rvalid_i = 1'b0;
    end

    // scoreboard: each accepted output is matched against the next expected PC
    initial forever begin
        @(negedge clk);
        if (!rst && valid_o && ready_i && exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            check("sb_pc", pc_o, sb_e);
            check("sb_instr", instr_o, ~sb_e);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[5] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[6] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[7] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h10};

        step();
        step();
        @(negedge clk);
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_fault", {31'b0, fault_o}, 32'd0);

        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            ready_i = tbl[i].ready;
            @(negedge clk);
            check($sformatf("tbl%0d_req", i), {31'b0, imem_req_o}, {31'b0, tbl[i].req});
            check($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), {31'b0, valid_o}, {31'b0, tbl[i].valid});
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].pc);
                check($sformatf("tbl%0d_instr", i), instr_o, ~tbl[i].pc);
            end
            step();
        end

        do_reset(1);
        ready_i = 1'b0;
        g0 = grants;
        repeat (12) step();
        @(negedge clk);
        check("stall_grants", 32'(grants - g0), 32'd4);
        check("stall_req", {31'b0, imem_req_o}, 32'd0);
        check("stall_valid", {31'b0, valid_o}, 32'd1);
        check("stall_pc", pc_o, 32'h0);
        step();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("release%0d_valid", i), {31'b0, valid_o}, 32'd1);
            step();
        end
        drain("stall_release");

        do_reset(3);
        repeat (3) step();
        redirect_to(32'h100);
        @(negedge clk);
        check("redir_req_low", {31'b0, imem_req_o}, 32'd0);
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        check("redir_valid_low", {31'b0, valid_o}, 32'd0);
        check("redir_req", {31'b0, imem_req_o}, 32'd1);
        check("redir_addr", imem_addr_o, 32'h100);
        exp_q = '{32'h100, 32'h104, 32'h108};
        drain("redir_late_drop");

        do_reset(1);
        repeat (5) step();
        redirect_to(32'h200);
        @(negedge clk);
        check("rr_valid", {31'b0, valid_o}, 32'd1);
        check("rr_pc", pc_o, 32'h8);
        step();
        redirect_i = 1'b0;
        @(negedge clk);
        check("rr_valid_low", {31'b0, valid_o}, 32'd0);
        exp_q = '{32'h200, 32'h204};
        drain("redir_with_rvalid");

        do_reset(1);
        repeat (3) step();
        imem_gnt_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("nognt%0d_req", i), {31'b0, imem_req_o}, 32'd1);
            check($sformatf("nognt%0d_addr", i), imem_addr_o, 32'h8);
            step();
        end
        imem_gnt_i = 1'b1;
        exp_q = '{32'h8, 32'hC};
        drain("nognt_resume");

        do_reset(1);
        repeat (3) step();
        redirect_to(32'hFFFF_FFF8);
        step();
        redirect_i = 1'b0;
        exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        drain("pc_wrap");

        do_reset(1);
        repeat (3) step();
        redirect_to(32'h102);
        step();
        redirect_i = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("halt%0d_fault", i), {31'b0, fault_o}, 32'd1);
            check($sformatf("halt%0d_req", i), {31'b0, imem_req_o}, 32'd0);
            check($sformatf("halt%0d_valid", i), {31'b0, valid_o}, 32'd0);
            step();
        end
`else
        @(negedge clk);
        check("align_fault", {31'b0, fault_o}, 32'd0);
        check("align_req", {31'b0, imem_req_o}, 32'd1);
        check("align_addr", imem_addr_o, 32'h100);
        exp_q = '{32'h100, 32'h104};
        drain("align_forced");
`endif

        rst = 1'b1;
        step();
        @(negedge clk);
        check("midrst_fault", {31'b0, fault_o}, 32'd0);
        check("midrst_valid", {31'b0, valid_o}, 32'd0);
        check("midrst_req", {31'b0, imem_req_o}, 32'd0);
        check("midrst_addr", imem_addr_o, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
